// File: rtl/ppmn_demod.sv
// ppmn_demod: M-ary pulse-position demodulator with sync hunt,
// length header and per-symbol erasure detection.
module ppmn_demod #(
    parameter int PPM_BITS  = 4,
    parameter int CHIP_BITS = 2,
    parameter int SYNC_SYMS = 4,
    parameter int LEN_BITS  = 8,
    parameter int TH_W      = $clog2(CHIP_BITS + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                din,
    input  logic                rx_start,
    input  logic [TH_W-1:0]     corr_threshold,
    output logic                packet_detected,
    output logic                dout_valid,
    output logic [PPM_BITS-1:0] dout,
    output logic                sym_err,
    output logic                rx_done
);

    localparam int M    = 1 << PPM_BITS;
    localparam int S    = CHIP_BITS;
    localparam int H    = (LEN_BITS + PPM_BITS - 1) / PPM_BITS;
    localparam int SW   = (S > 1) ? $clog2(S) : 1;
    localparam int YMAX = (SYNC_SYMS > H) ? SYNC_SYMS : H;
    localparam int YW   = (YMAX > 1) ? $clog2(YMAX) : 1;

    localparam logic [SW-1:0]       SAMP_LAST = SW'(S - 1);
    localparam logic [PPM_BITS-1:0] CHIP_LAST = PPM_BITS'(M - 1);
    localparam logic [YW-1:0]       SYNC_LAST = YW'(SYNC_SYMS - 1);
    localparam logic [YW-1:0]       HDR_LAST  = YW'(H - 1);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        SYNC,
        HDR,
        DATA
    } state_t;

    typedef struct packed {
        logic [PPM_BITS-1:0] val;
        logic                erase;
    } dec_t;

    state_t              state;
    logic [SW-1:0]       samp_cnt;
    logic [PPM_BITS-1:0] chip_cnt;
    logic [YW-1:0]       sym_cnt;
    logic [LEN_BITS-1:0] pay_cnt;
    logic [LEN_BITS-1:0] len;
    logic [TH_W-1:0]     chip_e;
    logic [TH_W-1:0]     best_e;
    logic [PPM_BITS-1:0] best_idx;

    logic                chip_last;
    logic                sym_last;
    logic                new_best;
    logic                framing;
    logic                pay_last;
    logic [TH_W-1:0]     e_now;
    logic [PPM_BITS-1:0] sym_val;
    logic [LEN_BITS-1:0] len_next;
    dec_t                dec;

    // Final decision folds the chip ending this cycle into the running max,
    // so the symbol result is registered on the same edge as its last sample.
    always_comb begin
        chip_last = (samp_cnt == SAMP_LAST);
        sym_last  = chip_last && (chip_cnt == CHIP_LAST);
        e_now     = chip_e + TH_W'(din);
        new_best  = (e_now > best_e);
        dec.val   = new_best ? chip_cnt : best_idx;
        dec.erase = ((new_best ? e_now : best_e) < corr_threshold);
        sym_val   = dec.erase ? '0 : dec.val;
        len_next  = (len << PPM_BITS) | LEN_BITS'(sym_val);
        pay_last  = (pay_cnt == len - LEN_BITS'(1));
        framing   = (state == SYNC) || (state == HDR) ||
                    (state == DATA) || ((state == HUNT) && din);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            samp_cnt        <= '0;
            chip_cnt        <= '0;
            sym_cnt         <= '0;
            pay_cnt         <= '0;
            len             <= '0;
            chip_e          <= '0;
            best_e          <= '0;
            best_idx        <= '0;
            packet_detected <= 1'b0;
            dout_valid      <= 1'b0;
            dout            <= '0;
            sym_err         <= 1'b0;
            rx_done         <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sym_err    <= 1'b0;
            rx_done    <= 1'b0;
            if (rx_start) begin
                state           <= HUNT;
                samp_cnt        <= '0;
                chip_cnt        <= '0;
                sym_cnt         <= '0;
                pay_cnt         <= '0;
                len             <= '0;
                chip_e          <= '0;
                best_e          <= '0;
                best_idx        <= '0;
                packet_detected <= 1'b0;
            end else begin
                if (framing) begin
                    if (chip_last) begin
                        samp_cnt <= '0;
                        chip_e   <= '0;
                        if (sym_last) begin
                            chip_cnt <= '0;
                            best_e   <= '0;
                            best_idx <= '0;
                        end else begin
                            chip_cnt <= chip_cnt + PPM_BITS'(1);
                            if (new_best) begin
                                best_e   <= e_now;
                                best_idx <= chip_cnt;
                            end
                        end
                    end else begin
                        samp_cnt <= samp_cnt + SW'(1);
                        chip_e   <= e_now;
                    end
                end
                unique case (state)
                    IDLE: begin
                        packet_detected <= 1'b0;
                    end
                    HUNT: begin
                        if (din) begin
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (sym_last) begin
                            if (dec.erase || (dec.val != '0)) begin
                                state   <= HUNT;
                                sym_cnt <= '0;
                            end else if (sym_cnt == SYNC_LAST) begin
                                state           <= HDR;
                                sym_cnt         <= '0;
                                len             <= '0;
                                packet_detected <= 1'b1;
                            end else begin
                                sym_cnt <= sym_cnt + YW'(1);
                            end
                        end
                    end
                    HDR: begin
                        if (sym_last) begin
                            len <= len_next;
                            if (sym_cnt == HDR_LAST) begin
                                sym_cnt <= '0;
                                pay_cnt <= '0;
                                if (len_next == '0) begin
                                    state           <= IDLE;
                                    rx_done         <= 1'b1;
                                    packet_detected <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                sym_cnt <= sym_cnt + YW'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (sym_last) begin
                            dout_valid <= 1'b1;
                            dout       <= sym_val;
                            sym_err    <= dec.erase;
                            if (pay_last) begin
                                // packet_detected drops on the next edge, in IDLE
                                state   <= IDLE;
                                rx_done <= 1'b1;
                            end else begin
                                pay_cnt <= pay_cnt + LEN_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppmn_demod.sv
// tb_ppmn_demod: directed vectors and packet sequences for ppmn_demod
// with defaults PPM_BITS=4, CHIP_BITS=2, SYNC_SYMS=4, LEN_BITS=8.
module tb_ppmn_demod;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       din = 1'b0;
    logic       rx_start = 1'b0;
    logic [1:0] corr_threshold = 2'd1;
    logic       packet_detected;
    logic       dout_valid;
    logic [3:0] dout;
    logic       sym_err;
    logic       rx_done;

    int checks = 0;
    int errors = 0;
    int stray = 0;
    logic [31:0] p;

    typedef struct {
        logic [31:0] pat;
        logic [1:0]  thr;
        logic [3:0]  exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vt [11];

    ppmn_demod dut (
        .clk(clk),
        .resetn(resetn),
        .din(din),
        .rx_start(rx_start),
        .corr_threshold(corr_threshold),
        .packet_detected(packet_detected),
        .dout_valid(dout_valid),
        .dout(dout),
        .sym_err(sym_err),
        .rx_done(rx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Tick that expects no output pulse
    task automatic qtick(input logic d);
        tick(d);
        if (dout_valid || sym_err || rx_done) stray++;
    endtask

    task automatic send_sym(input logic [31:0] pat);
        for (int i = 0; i < 31; i++) qtick(pat[i]);
        tick(pat[31]);
    endtask

    function automatic logic [31:0] sp(input logic [3:0] v);
        return 32'h3 << (2 * v);
    endfunction

    task automatic start();
        rx_start = 1'b1;
        tick(1'b0);
        rx_start = 1'b0;
    endtask

    task automatic sync4();
        for (int i = 0; i < 4; i++) send_sym(32'h3);
    endtask

    task automatic hdr(input logic [7:0] l);
        send_sym(sp(l[7:4]));
        send_sym(sp(l[3:0]));
    endtask

    task automatic pay(input string name, input logic [3:0] v,
                       input logic last);
        send_sym(sp(v));
        chk({name, "_dv"}, 32'(dout_valid), 1);
        chk({name, "_dout"}, 32'(dout), 32'(v));
        chk({name, "_err"}, 32'(sym_err), 0);
        chk({name, "_done"}, 32'(rx_done), 32'(last));
    endtask

    initial begin
        vt[0]  = '{32'h0000_0C00, 2'd1, 4'h5, 1'b0};
        vt[1]  = '{32'h0000_0000, 2'd1, 4'h0, 1'b1};
        vt[2]  = '{32'h0030_0000, 2'd1, 4'hA, 1'b0};
        vt[3]  = '{32'h000C_0030, 2'd1, 4'h2, 1'b0};
        vt[4]  = '{32'h0000_0000, 2'd0, 4'h0, 1'b0};
        vt[5]  = '{32'hC000_0000, 2'd1, 4'hF, 1'b0};
        vt[6]  = '{32'h0000_4000, 2'd2, 4'h0, 1'b1};
        vt[7]  = '{32'h0300_4000, 2'd2, 4'hC, 1'b0};
        vt[8]  = '{32'h0000_0084, 2'd1, 4'h1, 1'b0};
        vt[9]  = '{32'h000C_0000, 2'd3, 4'h0, 1'b1};
        vt[10] = '{32'hC000_0002, 2'd1, 4'hF, 1'b0};

        @(posedge clk);
        #1;
        chk("rst_pd", 32'(packet_detected), 0);
        chk("rst_dv", 32'(dout_valid), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_err", 32'(sym_err), 0);
        chk("rst_done", 32'(rx_done), 0);
        #2 resetn = 1'b1;

        // Baseline packet: header 3, payload 5,A,F
        start();
        for (int i = 0; i < 3; i++) qtick(1'b0);
        for (int i = 0; i < 3; i++) send_sym(32'h3);
        for (int i = 0; i < 31; i++) qtick(i < 2);
        chk("pd_before", 32'(packet_detected), 0);
        tick(1'b0);
        chk("pd_rise", 32'(packet_detected), 1);
        hdr(8'h03);
        chk("hdr_dv", 32'(dout_valid), 0);
        chk("hdr_pd", 32'(packet_detected), 1);
        pay("p0", 4'h5, 1'b0);
        pay("p1", 4'hA, 1'b0);
        pay("p2", 4'hF, 1'b1);
        qtick(1'b0);
        chk("end_pd", 32'(packet_detected), 0);
        chk("end_hold", 32'(dout), 32'hF);
        for (int i = 0; i < 40; i++) qtick(1'b1);
        chk("idle_pd", 32'(packet_detected), 0);
        chk("stray_a", 32'(stray), 0);

        // Vector table as one packet
        start();
        qtick(1'b0);
        sync4();
        hdr(8'd11);
        for (int i = 0; i < 11; i++) begin
            corr_threshold = vt[i].thr;
            send_sym(vt[i].pat);
            chk($sformatf("v%0d_dv", i), 32'(dout_valid), 1);
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vt[i].exp_d));
            chk($sformatf("v%0d_err", i), 32'(sym_err), 32'(vt[i].exp_e));
            chk($sformatf("v%0d_done", i), 32'(rx_done), 32'(i == 10));
        end
        corr_threshold = 2'd1;
        qtick(1'b0);
        chk("vt_pd", 32'(packet_detected), 0);
        chk("stray_b", 32'(stray), 0);

        // Sync failure on third symbol, then recovery
        start();
        send_sym(32'h3);
        send_sym(32'h3);
        send_sym(sp(4'h7));
        chk("sf_pd", 32'(packet_detected), 0);
        send_sym(32'h3);
        chk("sf_pd2", 32'(packet_detected), 0);
        send_sym(32'h0);
        for (int i = 0; i < 3; i++) qtick(1'b0);
        sync4();
        chk("sf_pd3", 32'(packet_detected), 1);
        hdr(8'h01);
        pay("sf_p", 4'h7, 1'b1);
        chk("stray_c", 32'(stray), 0);

        // Zero length header
        start();
        sync4();
        send_sym(sp(4'h0));
        for (int i = 0; i < 31; i++) qtick(i < 2);
        tick(1'b0);
        chk("z_done", 32'(rx_done), 1);
        chk("z_pd", 32'(packet_detected), 0);
        chk("z_dv", 32'(dout_valid), 0);
        for (int i = 0; i < 40; i++) qtick(i[0]);
        chk("stray_d", 32'(stray), 0);

        // Asynchronous reset during the second payload symbol
        start();
        sync4();
        hdr(8'h03);
        pay("r_p0", 4'h5, 1'b0);
        p = sp(4'h2);
        for (int i = 0; i < 10; i++) qtick(p[i]);
        #2 resetn = 1'b0;
        #1;
        chk("r_pd", 32'(packet_detected), 0);
        chk("r_dv", 32'(dout_valid), 0);
        chk("r_dout", 32'(dout), 0);
        chk("r_err", 32'(sym_err), 0);
        chk("r_done", 32'(rx_done), 0);
        #1 resetn = 1'b1;
        sync4();
        hdr(8'h01);
        send_sym(sp(4'h3));
        if (dout_valid || rx_done) stray++;
        chk("r_pd2", 32'(packet_detected), 0);
        chk("stray_e", 32'(stray), 0);

        // rx_start in the dout_valid cycle
        start();
        sync4();
        hdr(8'h02);
        pay("s_p0", 4'h9, 1'b0);
        rx_start = 1'b1;
        tick(1'b0);
        rx_start = 1'b0;
        chk("s_pd", 32'(packet_detected), 0);
        sync4();
        hdr(8'h01);
        pay("s_p1", 4'hD, 1'b1);

        // rx_start mid-DATA discards the partial symbol
        start();
        sync4();
        hdr(8'h02);
        p = sp(4'h4);
        for (int i = 0; i < 16; i++) qtick(p[i]);
        rx_start = 1'b1;
        tick(1'b0);
        rx_start = 1'b0;
        chk("m_pd", 32'(packet_detected), 0);
        qtick(1'b0);
        sync4();
        hdr(8'h01);
        pay("m_p", 4'h6, 1'b1);
        chk("stray_f", 32'(stray), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppmn_demod.md
PPMN_DEMOD -- requirements
Module: ppmn_demod

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PPM_BITS, 4, bits per symbol; M = 2^PPM_BITS chips per symbol.
- CHIP_BITS, 2, din samples per chip; S = CHIP_BITS.
- SYNC_SYMS, 4, sync symbols (value 0) preceding the header.
- LEN_BITS, 8, payload length field width; H = ceil(LEN_BITS/PPM_BITS) header symbols.
- TH_W = $clog2(CHIP_BITS+1), derived, threshold/energy width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic samples on its rising edge.
- resetn, in, 1, asynchronous active-low reset.
- din, in, 1, one detector sample per clk.
- rx_start, in, 1, one-cycle pulse; arms/re-arms the receiver.
- corr_threshold, in, TH_W, minimum winning chip energy for a valid symbol.
- packet_detected, out, 1, level; sync accepted, packet in progress.
- dout_valid, out, 1, one-cycle pulse per payload symbol.
- dout, out, PPM_BITS, decoded payload symbol; held between pulses.
- sym_err, out, 1, one-cycle pulse on an erased payload symbol.
- rx_done, out, 1, one-cycle pulse at packet end.

Function
REQ-003 States: IDLE, HUNT, SYNC, HDR, DATA. rx_start in any state forces HUNT next cycle, clearing counters, packet_detected and any partial symbol.
REQ-004 IDLE: din ignored, outputs quiescent.
REQ-005 HUNT: first sampled din=1 becomes sample 0 of chip 0 of sync symbol 0 with energy 1; next state SYNC.
REQ-006 Symbol framing: M*S consecutive samples; chip k = samples k*S..k*S+S-1; chip energy = count of ones in the chip (0..S).
REQ-007 Decision: value = index of the max-energy chip; ties resolve to the lowest index (strictly-greater update only); erasure if max energy < corr_threshold.
REQ-008 Decision is registered; it is usable the cycle after the symbol's last sample. The next symbol's sample 0 is taken in that same cycle, with no gap.
REQ-009 SYNC: SYNC_SYMS symbols, including the hunt symbol, must each decode to 0 without erasure. Any failure returns to HUNT after that symbol. On success, packet_detected=1 from the next cycle; next state HDR.
REQ-010 HDR: H symbols, MSB symbol first, shifted into length register L. Upper padding bits beyond LEN_BITS are discarded. A header erasure reads as 0.
REQ-011 After HDR, L==0 leads to rx_done pulse, packet_detected=0 and IDLE in the same cycle; otherwise next state DATA.
REQ-012 DATA: exactly L symbols. For each, dout_valid pulses for 1 cycle at decision (REQ-008 latency, S*M cycles per symbol).
- Valid symbol: dout = decoded value.
- Erasure: dout = 0 and sym_err pulses in the same cycle as dout_valid.
REQ-013 The cycle of the L-th dout_valid also pulses rx_done. packet_detected falls and the state is IDLE from the next cycle.
REQ-014 Counters: sample (0..S-1), chip (0..M-1) and symbol counters wrap exactly at their limits. Payload counter width is LEN_BITS; max L = 2^LEN_BITS-1.
REQ-015 corr_threshold is sampled per decision. A threshold of 0 never erases.
REQ-016 rx_start coincident with a dout_valid cycle: the pulse still issues and the state goes to HUNT.

Reset
REQ-017 resetn=0 asynchronously forces state IDLE; all counters, L and energy registers go to 0; packet_detected, dout_valid, sym_err and rx_done go to 0; dout goes to 0.
REQ-018 Reset mid-packet discards the packet. No output pulses follow reset release until a new rx_start.

Verification (PPM_BITS=4, CHIP_BITS=2, SYNC_SYMS=4, LEN_BITS=8, threshold=1)
REQ-019 Sequence of 4 sync symbols (pulse in chip 0), header 0x03, payload 5,A,F. Required:
- packet_detected rises 1 cycle after the 128th symbol sample.
- dout 5,A,F with dout_valid 32 cycles apart.
- rx_done on the third pulse.
REQ-020 Sync failure: third sync symbol has its pulse in chip 7. Required: no packet_detected, receiver back in HUNT, and a following good packet is decoded correctly.
REQ-021 Tie/erasure: payload symbol with both samples of chips 2 and 9 high gives dout=2. An all-zero symbol gives dout=0 with sym_err=1.
REQ-022 Zero length: header 0x00 gives rx_done 1 cycle after the last header sample and no dout_valid.
REQ-023 Reset and restart:
- resetn low during the 2nd payload symbol gives all outputs 0 immediately.
- rx_start mid-DATA drops packet_detected and re-enters HUNT.
